// File: rtl/reset_ctrl.sv
// Reset request sequencer: merges por/sw/wdt/dbg requests, holds both resets
// for a minimum width, releases peripherals then core, and keeps a sticky cause.
module reset_ctrl #(
  parameter int unsigned ASSERT_CYCLES  = 16,
  parameter int unsigned STAGGER_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_req_i,
  input  logic       wdt_req_i,
  input  logic       dbg_req_i,
  input  logic       dbg_hold_i,
  input  logic       cause_clr_i,
  output logic       periph_rst_n_o,
  output logic       core_rst_n_o,
  output logic [3:0] cause_o,
  output logic       busy_o
);

  localparam int unsigned CNT_MAX = (ASSERT_CYCLES > STAGGER_CYCLES) ? ASSERT_CYCLES : STAGGER_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] ASSERT_LAST  = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_STAGGER = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cause_d;
  logic             req_c;

  assign req_c = sw_req_i | wdt_req_i | dbg_req_i;

  // Next-state and counter; any request restarts the assertion window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ASSERT: begin
        if (req_c) begin
          cnt_d = '0;
        end else if (cnt_q < ASSERT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (dbg_hold_i) begin
          cnt_d = ASSERT_LAST;
        end else begin
          state_d = ST_STAGGER;
          cnt_d   = '0;
        end
      end
      ST_STAGGER: begin
        if (req_c) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
        end else if (cnt_q == STAGGER_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (req_c) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_ASSERT;
        cnt_d   = '0;
      end
    endcase
  end

  // Sticky cause: clear first so a same-cycle request still lands.
  always_comb begin
    cause_d = cause_clr_i ? 4'b0000 : cause_o;
    cause_d = cause_d | {dbg_req_i, wdt_req_i, sw_req_i, 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_ASSERT;
      cnt_q          <= '0;
      periph_rst_n_o <= 1'b0;
      core_rst_n_o   <= 1'b0;
      busy_o         <= 1'b1;
      cause_o        <= 4'b0001;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      periph_rst_n_o <= (state_d != ST_ASSERT);
      core_rst_n_o   <= (state_d == ST_RUN);
      busy_o         <= (state_d != ST_RUN);
      cause_o        <= cause_d;
    end
  end

endmodule

// File: tb/tb_reset_ctrl.sv
// Bench for reset_ctrl: directed scenarios then random traffic, checked every
// cycle against a timestamp-based model of release times and the cause register.
module tb_reset_ctrl;

  localparam int A_CYC = 16;
  localparam int S_CYC = 4;

  logic       clk = 1'b0;
  logic       rst, sw, wdt, dbg, hold, clr;
  logic       periph_n, core_n, busy;
  logic [3:0] cause;

  int ncmp = 0;
  int nfail = 0;

  // Model: edge index of the last rst/request, and of the peripheral release.
  int         n = 0;
  int         last_kill = 0;
  int         rel = -1;
  logic [3:0] m_cause = 4'b0000;
  bit         valid = 1'b0;

  reset_ctrl #(.ASSERT_CYCLES(A_CYC), .STAGGER_CYCLES(S_CYC)) dut (
    .clk            (clk),
    .rst            (rst),
    .sw_req_i       (sw),
    .wdt_req_i      (wdt),
    .dbg_req_i      (dbg),
    .dbg_hold_i     (hold),
    .cause_clr_i    (clr),
    .periph_rst_n_o (periph_n),
    .core_rst_n_o   (core_n),
    .cause_o        (cause),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s at edge %0d: got %b expected %b", tag, n, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s at edge %0d: got %b expected %b", tag, n, obs, exp);
    end
  endtask

  // One clock edge: update the model from the sampled inputs, then check.
  task automatic tick();
    logic req;
    logic p_exp, c_exp;
    @(posedge clk);
    n++;
    req = sw | wdt | dbg;
    if (rst) begin
      last_kill = n;
      rel       = -1;
      m_cause   = 4'b0001;
      valid     = 1'b1;
    end else begin
      m_cause = (clr ? 4'b0000 : m_cause) | {dbg, wdt, sw, 1'b0};
      if (req) begin
        last_kill = n;
        rel       = -1;
      end else if (rel < 0 && (n - last_kill) >= A_CYC && !hold) begin
        rel = n;
      end
    end
    #1;
    if (valid) begin
      p_exp = (rel >= 0);
      c_exp = (rel >= 0) && ((n - rel) >= S_CYC);
      chk1("periph_rst_n", periph_n, p_exp);
      chk1("core_rst_n", core_n, c_exp);
      chk1("busy", busy, !c_exp);
      chk4("cause", cause, m_cause);
    end
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  initial begin
    rst = 1'b1; sw = 1'b0; wdt = 1'b0; dbg = 1'b0; hold = 1'b0; clr = 1'b0;

    // Power-on reset, then the full 16+4 release
    ticks(3);
    chk4("por_cause", cause, 4'b0001);
    chk1("por_periph_low", periph_n, 1'b0);
    rst = 1'b0;
    ticks(15);
    chk1("por_periph_before", periph_n, 1'b0);
    tick();
    chk1("por_periph_rise", periph_n, 1'b1);
    ticks(4);
    chk1("por_core_rise", core_n, 1'b1);
    chk1("por_busy_fall", busy, 1'b0);

    // Software pulse from RUN, then clear
    sw = 1'b1; tick(); sw = 1'b0;
    chk1("sw_core_low", core_n, 1'b0);
    ticks(22);
    chk4("sw_cause", cause, 4'b0011);
    clr = 1'b1; tick(); clr = 1'b0;
    chk4("clr_cause", cause, 4'b0000);

    // Watchdog restart mid-ASSERT, debug restart in STAGGER
    sw = 1'b1; tick(); sw = 1'b0;
    ticks(10);
    wdt = 1'b1; tick(); wdt = 1'b0;
    ticks(17);
    chk1("restart_in_stagger", periph_n, 1'b1);
    dbg = 1'b1; tick(); dbg = 1'b0;
    chk1("dbg_periph_drop", periph_n, 1'b0);
    ticks(25);
    chk4("restart_cause", cause, 4'b1110);

    // Debug hold keeps resets low well past the minimum width
    hold = 1'b1;
    sw = 1'b1; tick(); sw = 1'b0;
    ticks(100);
    chk1("hold_periph_low", periph_n, 1'b0);
    hold = 1'b0;
    tick();
    chk1("hold_release", periph_n, 1'b1);
    ticks(10);

    // Clear colliding with a request, then two simultaneous requests
    clr = 1'b1; sw = 1'b1; tick(); clr = 1'b0; sw = 1'b0;
    chk4("clr_collide", cause, 4'b0010);
    ticks(25);
    sw = 1'b1; wdt = 1'b1; tick(); sw = 1'b0; wdt = 1'b0;
    ticks(25);
    chk4("dual_cause", cause, 4'b0110);

    // rst during STAGGER restarts everything
    sw = 1'b1; tick(); sw = 1'b0;
    ticks(17);
    rst = 1'b1; tick(); rst = 1'b0;
    chk4("mid_por_cause", cause, 4'b0001);
    ticks(25);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 399) == 0);
      sw   = ($urandom_range(0, 59) == 0);
      wdt  = ($urandom_range(0, 59) == 0);
      dbg  = ($urandom_range(0, 59) == 0);
      clr  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 19) == 0) hold = ~hold;
      tick();
    end
    rst = 1'b0; sw = 1'b0; wdt = 1'b0; dbg = 1'b0; clr = 1'b0; hold = 1'b0;
    ticks(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/reset_ctrl.md
Name: reset_ctrl

Overview:
- Reset request generator and sequencer. It is the source end of the system reset path and produces the active-low resets consumed by the reset buffer/distribution stage.
- Collects reset requests (power-on, software, watchdog, debug) and asserts reset for a guaranteed minimum width.
- Releases peripherals first and the core a fixed number of cycles later.
- Records the reset cause in a sticky register that firmware can read after boot.

Parameters:
- ASSERT_CYCLES, 16, minimum number of cycles both resets stay low after the last request; must be >= 2.
- STAGGER_CYCLES, 4, cycles between peripheral release and core release; must be >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high power-on/external reset
- sw_req_i  in  1  software reset request, level or pulse
- wdt_req_i  in  1  watchdog reset request, level or pulse
- dbg_req_i  in  1  debugger reset request, level or pulse
- dbg_hold_i  in  1  debugger hold; keeps the sequencer in ASSERT while high
- cause_clr_i  in  1  single-cycle pulse that clears cause_o
- periph_rst_n_o  out  1  active-low peripheral reset, registered
- core_rst_n_o  out  1  active-low core reset, registered
- cause_o  out  4  sticky cause bits {dbg, wdt, sw, por}
- busy_o  out  1  high whenever the core is held in reset

Behaviour:
- All outputs are registered. Reset is synchronous, active-high on rst; rst overrides everything.
- While rst=1 at an edge:
  - state=ASSERT, cnt=0
  - periph_rst_n_o=0, core_rst_n_o=0, busy_o=1
  - cause_o=4'b0001
- Define req = sw_req_i | wdt_req_i | dbg_req_i.
- ASSERT state:
  - periph_rst_n_o=0, core_rst_n_o=0, busy_o=1.
  - req=1 at an edge: cnt:=0 (assertion restarts).
  - Otherwise, if cnt < ASSERT_CYCLES-1: cnt increments.
  - Otherwise, if dbg_hold_i=1: cnt saturates at ASSERT_CYCLES-1 and the state stays ASSERT.
  - Otherwise: state:=STAGGER, cnt:=0, periph_rst_n_o:=1.
- STAGGER state:
  - periph_rst_n_o=1, core_rst_n_o=0, busy_o=1.
  - req=1: state:=ASSERT, cnt:=0, periph_rst_n_o:=0.
  - Otherwise, if cnt==STAGGER_CYCLES-1: state:=RUN, core_rst_n_o:=1, busy_o:=0.
  - Otherwise: cnt increments.
- RUN state:
  - Both resets =1, busy_o=0.
  - req=1: state:=ASSERT, cnt:=0, and both resets plus busy_o take their ASSERT values after that same edge (one-cycle latency).
- Timing, taking E0 as the last edge at which rst or req was sampled high:
  - periph_rst_n_o rises at E0+ASSERT_CYCLES.
  - core_rst_n_o rises at E0+ASSERT_CYCLES+STAGGER_CYCLES.
  - Holds provided there is no hold and no new request.
- Level requests held high keep the block in ASSERT indefinitely.
- dbg_hold_i has no effect outside ASSERT.
- Cause register:
  - Every edge: cause_o[1] |= sw_req_i, cause_o[2] |= wdt_req_i, cause_o[3] |= dbg_req_i.
  - Bits are captured in any state, including while already in ASSERT.
  - cause_clr_i=1 clears all four bits.
  - If a request arrives in the same cycle as cause_clr_i, the request bit is set and the others are cleared (set wins).
  - Bit 0 (por) is set only by rst.
  - cause_o is unaffected by sw/wdt/dbg-initiated resets apart from the set rule, so it survives the resets this block issues.
- Multiple simultaneous requests: all corresponding cause bits are set; there is a single reset sequence.
- Counter width is $clog2(max(ASSERT_CYCLES, STAGGER_CYCLES)). The counter never wraps; it saturates in ASSERT as specified.
- rst asserted mid-sequence (any state) returns the block to the reset values on the next edge and sets cause_o to 4'b0001, discarding older bits.

Test Plan:
- POR: rst=1 for 3 cycles, then 0 at edge E0.
  - Both resets low and cause_o=4'b0001 during reset.
  - periph_rst_n_o rises at E0+16, core_rst_n_o at E0+20, busy_o falls at E0+20.
- SW pulse in RUN: sw_req_i high for 1 cycle at edge E.
  - Both resets low from E+1; periph rises at E+16, core at E+20.
  - cause_o=4'b0011.
  - Then cause_clr_i pulse gives cause_o=4'b0000.
- Restart:
  - wdt_req_i pulse at cnt=10 in ASSERT: periph release slips to 16 cycles after the new pulse.
  - dbg_req_i pulse in STAGGER: periph drops next cycle and the full 16+4 sequence repeats.
  - cause_o has bits 2 and 3 set.
- Debug hold: dbg_hold_i=1 through ASSERT.
  - Resets stay low for 100 cycles.
  - Drop hold: periph rises the next edge, core 4 cycles later.
- Collisions:
  - cause_clr_i and sw_req_i in the same cycle give cause_o=4'b0010.
  - sw and wdt requested together set both bits and run a single sequence.
- Mid-sequence POR: rst pulse during STAGGER gives both resets low, cause_o=4'b0001, and the full timing restarts.
